jacobian_cols: RTL
==================

// Module: jacobian_cols
// PURPOSE
//  Builds the 6x6 geometric Jacobian from the six cumulative transforms T_01..T_06
//  that full_mat writes into full_matrix.
//  Column k = [z_{k-1} x (p_e - p_{k-1}) ; z_{k-1}], with z_0=(0,0,1) and p_0=(0,0,0).
//  For k>=1, z and p are read from full_matrix[k-1]; p_e is read from full_matrix[5].
//  Sits directly downstream of full_mat. Time-multiplexes one external 27-bit FP
//  multiplier and one FP subtractor, in the same style as the shared array_mult.
// PARAMETERS
//  MUL_LAT  5  cycles from mult_dataa/datab issue to matching mult_result
//  SUB_LAT  7  cycles from sub_dataa/datab issue to matching sub_result
// PORTS
//  clk          in   1              clock; all logic on posedge
//  rst          in   1              synchronous active-high reset
//  en           in   1              clock enable; low freezes all state and outputs
//  start        in   1              request; sampled only in IDLE
//  full_matrix  in   [5:0][3:0][3:0][26:0]  [k][row][col]; col 2 = z axis, col 3 = position
//  busy         out  1              high from the cycle after start is accepted until done
//  done         out  1              one-cycle pulse; jacobian complete
//  jacobian     out  [5:0][5:0][26:0]  [col][row]; rows 0-2 linear, rows 3-5 angular
//  mult_dataa   out  27             multiplier operand A
//  mult_datab   out  27             multiplier operand B
//  mult_result  in   27             multiplier product
//  sub_dataa    out  27             subtractor minuend
//  sub_datab    out  27             subtractor subtrahend; unit computes a-b
//  sub_result   in   27             subtractor difference
// BEHAVIOUR
//  - Word format: 27-bit float (sign, 8-bit exponent, 18-bit mantissa).
//    1.0 = 27'h1FC0000; 0.0 = 27'h0. Operands pass through untouched.
//  - Reset: state IDLE; col=0; busy=0; done=0; jacobian all 0; all operand outputs 0.
//  - en=0: no state, counter or output changes. Top must gate the arith units with the same en.
//  - FSM: IDLE -> SUB_D -> MUL -> SUB_X -> STORE -> (col<5 ? SUB_D, col+1 : IDLE with done=1).
//  - Phase counter cnt restarts at 0 on entry to each phase.
//  - SUB_D (SUB_LAT+3 cycles):
//      issue cnt=0..2: d_j = pe_j - p_j
//      capture d[cnt-SUB_LAT] for SUB_LAT <= cnt < SUB_LAT+3
//  - MUL (MUL_LAT+6 cycles):
//      issue order z1*d2, z2*d1, z2*d0, z0*d2, z0*d1, z1*d0 at cnt=0..5
//      capture m[cnt-MUL_LAT]
//  - SUB_X (SUB_LAT+3 cycles):
//      issue m0-m1, m2-m3, m4-m5 at cnt=0..2
//      capture into v[0..2] with the same rule as SUB_D
//  - STORE (1 cycle): jacobian[col][0..2] <= v; jacobian[col][3..5] <= z.
//  - Per-column latency C = 2*SUB_LAT + MUL_LAT + 13 (default 32).
//    done is asserted 6*C cycles after the start-accept edge (192 by default).
//  - Operand outputs are 27'h0 in every cycle that is not an issue cycle.
//  - The done pulse is registered and coincides with the first IDLE cycle.
//    start in that same cycle is accepted.
//  - start while busy is ignored, with no effect on the run.
//  - full_matrix must be held stable while busy; it is not snapshotted.
//  - jacobian is not cleared on start; columns are overwritten in order 0..5.
//  - rst mid-run: back to reset values next edge; no done is produced.
//    In-flight external results are discarded, because capture only occurs in-phase.
// CONFIGURATION
//  JACOBIAN_EE_POS_EN defined:
//    adds output ee_pos out [2:0][26:0], reset 0.
//    Loaded with (pe_0,pe_1,pe_2) in the same cycle done pulses, for the error stage.
//  JACOBIAN_EE_POS_EN undefined:
//    no ee_pos port and no extra flops; all else identical.
// TESTING
//  (bench uses behavioural FP mult/sub models honouring MUL_LAT/SUB_LAT)
//  1. All T_0k: z=(0,0,1), position=(k+1,0,0); pulse start
//     -> done at +192; for each col c: jacobian[c]=(0,6-c,0,0,0,1).
//  2. full_matrix[0] z=(1,0,0), position 0; p_e=(0,2,0)
//     -> jacobian[1]=(0,0,2,1,0,0) (27'h0,27'h0,27'h2000000,27'h1FC0000,0,0).
//  3. rst pulsed at cycle 50 of a run
//     -> busy=0, jacobian all 0, operands 0, no done; a fresh start then matches test 1 exactly.
//  4. start re-pulsed at cycles 10 and 100 of a run, plus en=0 for 20 cycles mid-run
//     -> single done at +212; results identical to test 1.
//  5. start held high through the done cycle
//     -> second run begins immediately; second done at +192 after the first.
//  6. Build with JACOBIAN_EE_POS_EN, stimulus of test 1
//     -> ee_pos=(6.0,0,0) on the done cycle and holds; 0 before.
//     Without the macro, the port is absent and the same stimulus passes test 1.

Source files
------------

// File: rtl/jacobian_cols.sv
// jacobian_cols: builds the 6x6 geometric Jacobian one column at a time from full_mat's
// cumulative transforms, time-sharing one external FP multiplier and one FP subtractor.
// Optional feature macro: JACOBIAN_EE_POS_EN adds the registered ee_pos output.
module jacobian_cols #(
  parameter int MUL_LAT = 5,
  parameter int SUB_LAT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  input  logic [5:0][3:0][3:0][26:0] full_matrix,
  output logic                       busy,
  output logic                       done,
  output logic [5:0][5:0][26:0]      jacobian,
  output logic [26:0]                mult_dataa,
  output logic [26:0]                mult_datab,
  input  logic [26:0]                mult_result,
  output logic [26:0]                sub_dataa,
  output logic [26:0]                sub_datab,
  input  logic [26:0]                sub_result
`ifdef JACOBIAN_EE_POS_EN
  ,
  output logic [2:0][26:0]           ee_pos
`endif
);

  localparam int PH_MAX = (SUB_LAT + 3 > MUL_LAT + 6) ? SUB_LAT + 3 : MUL_LAT + 6;
  localparam int CNT_W  = $clog2(PH_MAX);

  localparam logic [CNT_W-1:0] SUB_CAP = CNT_W'(SUB_LAT);
  localparam logic [CNT_W-1:0] SUB_END = CNT_W'(SUB_LAT + 2);
  localparam logic [CNT_W-1:0] MUL_CAP = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_LAT + 5);
  localparam logic [CNT_W-1:0] N_SUB   = CNT_W'(3);
  localparam logic [CNT_W-1:0] N_MUL   = CNT_W'(6);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [26:0]      FP_ONE  = 27'h1FC0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB_D,
    S_MUL,
    S_SUB_X,
    S_STORE
  } state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [2:0]            r_col, w_col_nx, w_prev;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;
  logic                  w_store;
  logic [5:0][5:0][26:0] r_jac;

  logic [26:0] r_d [3];
  logic [26:0] r_m [6];
  logic [26:0] r_v [3];
  logic [26:0] w_z [3];
  logic [26:0] w_p [3];
  logic [26:0] w_pe [3];

  logic [1:0] w_sub_idx;
  logic [2:0] w_mul_idx;
  logic       w_sub_cap, w_mul_cap;
  logic       w_unused;

  // Only the z and position columns of rows 0-2 are consumed.
  assign w_unused = ^full_matrix;

  assign w_prev    = r_col - 3'd1;
  assign w_sub_idx = 2'(r_cnt - SUB_CAP);
  assign w_mul_idx = 3'(r_cnt - MUL_CAP);
  assign w_sub_cap = (r_cnt >= SUB_CAP);
  assign w_mul_cap = (r_cnt >= MUL_CAP);

  // Frame of joint k-1 for the current column; column 0 uses the base frame.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_pe[r] = full_matrix[5][r][3];
      if (r_col == 3'd0) begin
        w_z[r] = (r == 2) ? FP_ONE : 27'h0;
        w_p[r] = 27'h0;
      end else begin
        w_z[r] = full_matrix[w_prev][r][2];
        w_p[r] = full_matrix[w_prev][r][3];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_ONE;
    w_col_nx   = r_col;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_store    = 1'b0;
    mult_dataa = 27'h0;
    mult_datab = 27'h0;
    sub_dataa  = 27'h0;
    sub_datab  = 27'h0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (start) begin
          w_state_nx = S_SUB_D;
          w_col_nx   = 3'd0;
          w_busy_nx  = 1'b1;
        end
      end
      S_SUB_D: begin
        if (r_cnt < N_SUB) begin
          sub_dataa = w_pe[r_cnt[1:0]];
          sub_datab = w_p[r_cnt[1:0]];
        end
        if (r_cnt == SUB_END) begin
          w_state_nx = S_MUL;
          w_cnt_nx   = '0;
        end
      end
      S_MUL: begin
        if (r_cnt < N_MUL) begin
          case (r_cnt[2:0])
            3'd0:    begin mult_dataa = w_z[1]; mult_datab = r_d[2]; end
            3'd1:    begin mult_dataa = w_z[2]; mult_datab = r_d[1]; end
            3'd2:    begin mult_dataa = w_z[2]; mult_datab = r_d[0]; end
            3'd3:    begin mult_dataa = w_z[0]; mult_datab = r_d[2]; end
            3'd4:    begin mult_dataa = w_z[0]; mult_datab = r_d[1]; end
            default: begin mult_dataa = w_z[1]; mult_datab = r_d[0]; end
          endcase
        end
        if (r_cnt == MUL_END) begin
          w_state_nx = S_SUB_X;
          w_cnt_nx   = '0;
        end
      end
      S_SUB_X: begin
        if (r_cnt < N_SUB) begin
          sub_dataa = r_m[{r_cnt[1:0], 1'b0}];
          sub_datab = r_m[{r_cnt[1:0], 1'b1}];
        end
        if (r_cnt == SUB_END) begin
          w_state_nx = S_STORE;
          w_cnt_nx   = '0;
        end
      end
      S_STORE: begin
        w_store  = 1'b1;
        w_cnt_nx = '0;
        if (r_col == 3'd5) begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else begin
          w_state_nx = S_SUB_D;
          w_col_nx   = r_col + 3'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_jac   <= '0;
    end else if (en) begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_col   <= w_col_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      if (w_store) begin
        for (int r = 0; r < 3; r++) begin
          r_jac[r_col][r]     <= r_v[r];
          r_jac[r_col][r + 3] <= w_z[r];
        end
      end
    end
  end

  // NOTE: scratch operands carry no reset; each is rewritten in-phase before it is read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (r_state == S_SUB_D && w_sub_cap) r_d[w_sub_idx] <= sub_result;
      if (r_state == S_MUL   && w_mul_cap) r_m[w_mul_idx] <= mult_result;
      if (r_state == S_SUB_X && w_sub_cap) r_v[w_sub_idx] <= sub_result;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign jacobian = r_jac;

`ifdef JACOBIAN_EE_POS_EN
  logic [2:0][26:0] r_ee_pos;

  // End-effector position is latched alongside the done pulse for the error stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ee_pos <= '0;
    end else if (en && w_done_nx) begin
      for (int r = 0; r < 3; r++) r_ee_pos[r] <= w_pe[r];
    end
  end

  assign ee_pos = r_ee_pos;
`endif

endmodule
